// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe scroll-field scheduler.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PIPE = 2'd2
    } sched_state_t;

    // Field height: one bit per row of the 16x16 scroll field.
    localparam int ROWS = 16;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 with the register shifting
    // toward bit 0: exponents 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // One LFSR step: XOR of the tapped bits enters at the top.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/pipe_tick_div.sv
// Column-shift period divider: counts 0..P-1 while running and raises tick
// on the terminal count. P = TICK_BASE >> speed is re-sampled at every wrap
// and while cleared, so a speed change lands on the next period boundary.
module pipe_tick_div #(
    parameter int TICK_BASE = 2_000_000
) (
    input  logic       Clock,
    input  logic       RST,
    input  logic       clr,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CNT_W = $clog2(TICK_BASE + 1);

    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] period_p0;
    logic [CNT_W-1:0] period_sel;
    logic             at_end;

    assign period_sel = CNT_W'(TICK_BASE >> speed);
    assign at_end     = (cnt_p0 == period_p0 - CNT_W'(1));
    assign tick       = run && !clr && at_end;

    // Period counter: clear wins, then wrap on tick, else advance while running.
    always_ff @(posedge Clock) begin
        if (!RST) begin
            cnt_p0    <= '0;
            period_p0 <= CNT_W'(TICK_BASE);
        end else if (clr) begin
            cnt_p0    <= '0;
            period_p0 <= period_sel;
        end else if (tick) begin
            cnt_p0    <= '0;
            period_p0 <= period_sel;
        end else if (run) begin
            cnt_p0    <= cnt_p0 + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe scroll-field sequencer: emits GAP_W empty columns then PIPE_W pipe
// columns with an LFSR-placed opening, one column per shift pulse, and
// counts completed pipes.
module pipe_scheduler
    import pipe_pkg::*;
#(
    parameter int          TICK_BASE = 2_000_000,
    parameter int          GAP_W     = 6,
    parameter int          PIPE_W    = 2,
    parameter int          OPEN_H    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            Clock,
    input  logic            RST,
    input  logic            start,
    input  logic            freeze,
    input  logic [1:0]      speed,
    output logic            shift_en,
    output logic [ROWS-1:0] genPipes,
    output logic [7:0]      pipe_count
);

    localparam int COL_MAX = (GAP_W > PIPE_W) ? GAP_W : PIPE_W;
    localparam int COL_W   = $clog2(COL_MAX + 1);
    localparam int OFF_MOD = 15 - OPEN_H;

    // Opening start row: 1 + (raw mod (15-OPEN_H)), keeping rows 0 and 15 solid.
    function automatic logic [3:0] offset_of(input logic [3:0] raw);
        return 4'(1 + (int'(raw) % OFF_MOD));
    endfunction

    // Pipe column: solid except the OPEN_H rows starting at off.
    function automatic logic [ROWS-1:0] mask_of(input logic [3:0] off);
        logic [ROWS-1:0] m;
        for (int r = 0; r < ROWS; r++) begin
            m[r] = !((r >= int'(off)) && (r < int'(off) + OPEN_H));
        end
        m[0]      = 1'b1;
        m[ROWS-1] = 1'b1;
        return m;
    endfunction

    // Pipe counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    sched_state_t    state_p0, state_nx;
    logic [COL_W-1:0] col_p0, col_nx;
    logic [15:0]     lfsr_p0, lfsr_nx;
    logic [3:0]      off_p0, off_nx;
    logic            shift_en_p0, shift_en_nx;
    logic [ROWS-1:0] gen_p0, gen_nx;
    logic [7:0]      count_p0, count_nx;

    logic            tick_clr;
    logic            tick;

    // Counter sits cleared whenever the game is not actively scrolling.
    assign tick_clr = (state_p0 == IDLE) || !start;

    pipe_tick_div #(
        .TICK_BASE (TICK_BASE)
    ) u_tick (
        .Clock (Clock),
        .RST   (RST),
        .clr   (tick_clr),
        .run   (!freeze),
        .speed (speed),
        .tick  (tick)
    );

    // State and output registers; shift_en and the column update together.
    always_ff @(posedge Clock) begin
        if (!RST) begin
            state_p0    <= IDLE;
            col_p0      <= '0;
            lfsr_p0     <= LFSR_SEED;
            off_p0      <= 4'd1;
            shift_en_p0 <= 1'b0;
            gen_p0      <= '0;
            count_p0    <= '0;
        end else begin
            state_p0    <= state_nx;
            col_p0      <= col_nx;
            lfsr_p0     <= lfsr_nx;
            off_p0      <= off_nx;
            shift_en_p0 <= shift_en_nx;
            gen_p0      <= gen_nx;
            count_p0    <= count_nx;
        end
    end

    // Next-state: stop beats tick; freeze is already folded into tick.
    always_comb begin
        state_nx    = state_p0;
        col_nx      = col_p0;
        lfsr_nx     = lfsr_p0;
        off_nx      = off_p0;
        shift_en_nx = 1'b0;
        gen_nx      = gen_p0;
        count_nx    = count_p0;

        case (state_p0)
            IDLE: begin
                gen_nx = '0;
                if (start) begin
                    state_nx = GAP;
                    col_nx   = '0;
                    count_nx = '0;
                end
            end

            GAP: begin
                if (!start) begin
                    state_nx = IDLE;
                    col_nx   = '0;
                    gen_nx   = '0;
                end else if (tick) begin
                    shift_en_nx = 1'b1;
                    lfsr_nx     = lfsr_next(lfsr_p0);
                    gen_nx      = '0;
                    if (col_p0 == COL_W'(GAP_W - 1)) begin
                        state_nx = PIPE;
                        col_nx   = '0;
                        off_nx   = offset_of(lfsr_p0[3:0]);
                    end else begin
                        col_nx   = col_p0 + COL_W'(1);
                    end
                end
            end

            PIPE: begin
                if (!start) begin
                    state_nx = IDLE;
                    col_nx   = '0;
                    gen_nx   = '0;
                end else if (tick) begin
                    shift_en_nx = 1'b1;
                    lfsr_nx     = lfsr_next(lfsr_p0);
                    gen_nx      = mask_of(off_p0);
                    if (col_p0 == COL_W'(PIPE_W - 1)) begin
                        state_nx = GAP;
                        col_nx   = '0;
                        count_nx = sat_inc(count_p0);
                    end else begin
                        col_nx   = col_p0 + COL_W'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                col_nx   = '0;
                gen_nx   = '0;
            end
        endcase
    end

    assign shift_en   = shift_en_p0;
    assign genPipes   = gen_p0;
    assign pipe_count = count_p0;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: vector table, directed timing sequences, and a
// randomized run checked against a shift-indexed reference model.
module tb_pipe_scheduler;

    localparam int          TB   = 8;
    localparam int          GW   = 6;
    localparam int          PW   = 2;
    localparam int          OH   = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          SPAN = GW + PW;

    logic        Clock = 1'b0;
    logic        RST   = 1'b0;
    logic        start = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        shift_en;
    logic [15:0] genPipes;
    logic [7:0]  pipe_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pulse = 0;
    logic timed_out = 1'b0;

    // Reference model: column sequence as a function of shift index.
    logic [15:0] m_lfsr = SEED;
    int          m_shifts = 0;
    int          m_pipes = 0;
    int          m_off = 1;

    typedef struct {
        logic        rst_n;
        logic        st;
        logic        frz;
        logic [1:0]  spd;
        int          cycles;
        logic        exp_se;
        logic [15:0] exp_gp;
        logic [7:0]  exp_pc;
    } vec_t;

    pipe_scheduler #(
        .TICK_BASE (TB),
        .GAP_W     (GW),
        .PIPE_W    (PW),
        .OPEN_H    (OH),
        .LFSR_SEED (SEED)
    ) dut (
        .Clock      (Clock),
        .RST        (RST),
        .start      (start),
        .freeze     (freeze),
        .speed      (speed),
        .shift_en   (shift_en),
        .genPipes   (genPipes),
        .pipe_count (pipe_count)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Polynomial x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
    function automatic logic [15:0] golden_lfsr(input logic [15:0] l);
        logic fb;
        fb = l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11];
        return {fb, l[15:1]};
    endfunction

    function automatic int exp_offset(input logic [15:0] l);
        return 1 + (int'(l[3:0]) % (15 - OH));
    endfunction

    function automatic logic [15:0] exp_mask(input int off);
        logic [15:0] m;
        m = 16'hFFFF;
        for (int r = off; r < off + OH; r++) m[r] = 1'b0;
        return m;
    endfunction

    function automatic int lowest_zero(input logic [15:0] g);
        for (int r = 0; r < 16; r++) if (!g[r]) return r;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_start();
        m_shifts = 0;
        m_pipes  = 0;
    endtask

    // Called on every observed pulse: checks the column and pipe count.
    task automatic sb_pulse();
        int pos;
        logic [15:0] expcol;
        pos = m_shifts % SPAN;
        if (pos == GW - 1) m_off = exp_offset(m_lfsr);
        expcol = (pos < GW) ? 16'h0000 : exp_mask(m_off);
        m_lfsr = golden_lfsr(m_lfsr);
        if (pos == SPAN - 1 && m_pipes < 255) m_pipes++;
        m_shifts++;
        check("column", 32'(genPipes), 32'(expcol));
        check("pipe_count", 32'(pipe_count), 32'(m_pipes));
    endtask

    task automatic wait_pulse(input int budget, output int interval);
        int n;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!shift_en && n < budget);
        if (!shift_en) begin
            timed_out = 1'b1;
            interval  = -1;
            check("pulse_timeout", 32'(0), 32'(1));
        end else begin
            interval   = cyc - last_pulse;
            last_pulse = cyc;
            sb_pulse();
        end
    endtask

    task automatic do_reset();
        RST    = 1'b0;
        start  = 1'b0;
        freeze = 1'b0;
        repeat (2) @(negedge Clock);
        RST    = 1'b1;
        m_lfsr = SEED;
        sb_start();
    endtask

    initial begin : main
        vec_t        vecs[13];
        int          iv;
        int          lz;
        int          exp_period;
        int          act;
        logic        f;
        logic [15:0] g6, g7, held_gp, prev_gp, z;
        logic [7:0]  held_pc;

        //           rst  st   frz  spd  cyc  se   gp        pc
        vecs[0]  = '{1'b0,1'b0,1'b0,2'd0, 2, 1'b0,16'h0000,8'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,2'd0, 1, 1'b0,16'h0000,8'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,2'd0, 7, 1'b0,16'h0000,8'd0};
        vecs[3]  = '{1'b1,1'b1,1'b0,2'd0, 1, 1'b1,16'h0000,8'd0};
        vecs[4]  = '{1'b1,1'b1,1'b0,2'd0, 1, 1'b0,16'h0000,8'd0};
        vecs[5]  = '{1'b1,1'b1,1'b0,2'd0, 6, 1'b0,16'h0000,8'd0};
        vecs[6]  = '{1'b1,1'b1,1'b0,2'd0, 1, 1'b1,16'h0000,8'd0};
        vecs[7]  = '{1'b1,1'b0,1'b0,2'd0, 1, 1'b0,16'h0000,8'd0};
        vecs[8]  = '{1'b1,1'b1,1'b1,2'd0,20, 1'b0,16'h0000,8'd0};
        vecs[9]  = '{1'b1,1'b1,1'b0,2'd0, 7, 1'b0,16'h0000,8'd0};
        vecs[10] = '{1'b1,1'b1,1'b0,2'd0, 1, 1'b1,16'h0000,8'd0};
        vecs[11] = '{1'b0,1'b1,1'b0,2'd0, 1, 1'b0,16'h0000,8'd0};
        vecs[12] = '{1'b1,1'b0,1'b0,2'd0,10, 1'b0,16'h0000,8'd0};

        for (int i = 0; i < 13; i++) begin
            RST    = vecs[i].rst_n;
            start  = vecs[i].st;
            freeze = vecs[i].frz;
            speed  = vecs[i].spd;
            repeat (vecs[i].cycles) @(negedge Clock);
            check($sformatf("vec%0d_shift_en", i), 32'(shift_en), 32'(vecs[i].exp_se));
            check($sformatf("vec%0d_genPipes", i), 32'(genPipes), 32'(vecs[i].exp_gp));
            check($sformatf("vec%0d_pipe_count", i), 32'(pipe_count), 32'(vecs[i].exp_pc));
        end
        m_lfsr = SEED;

        // First full pipe at speed 0, then reset in the middle of the next pipe.
        sb_start();
        speed = 2'd0;
        start = 1'b1;
        last_pulse = cyc + 1;
        g6 = 16'h0;
        g7 = 16'h0;
        for (int i = 0; i < SPAN && !timed_out; i++) begin
            wait_pulse(20, iv);
            check("period_speed0", 32'(iv), 32'(TB));
            if (i == GW) g6 = genPipes;
            if (i == GW + 1) g7 = genPipes;
        end
        check("pipe_cols_equal", 32'(g7), 32'(g6));
        check("pipe_edge_rows", 32'({g6[15], g6[0]}), 32'(2'b11));
        lz = lowest_zero(g6);
        z  = ~g6;
        check("opening_contig", 32'(z >> ((lz < 0) ? 0 : lz)), 32'((1 << OH) - 1));
        check("first_pipe_count", 32'(pipe_count), 32'(1));
        for (int i = 0; i < GW + 1 && !timed_out; i++) wait_pulse(20, iv);
        RST = 1'b0;
        repeat (2) @(negedge Clock);
        check("midpipe_rst_shift_en", 32'(shift_en), 32'(0));
        check("midpipe_rst_genPipes", 32'(genPipes), 32'(0));
        check("midpipe_rst_pipe_count", 32'(pipe_count), 32'(0));
        RST   = 1'b1;
        start = 1'b0;
        m_lfsr = SEED;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            check("idle_quiet", 32'(shift_en), 32'(0));
        end

        // Speed change mid-period: current period completes first.
        sb_start();
        start = 1'b1;
        last_pulse = cyc + 1;
        wait_pulse(20, iv);
        check("speed_first_period", 32'(iv), 32'(TB));
        repeat (3) @(negedge Clock);
        speed = 2'd2;
        wait_pulse(20, iv);
        check("speed_change_finish", 32'(iv), 32'(TB));
        for (int i = 0; i < 3 && !timed_out; i++) begin
            wait_pulse(20, iv);
            check("speed2_period", 32'(iv), 32'(TB >> 2));
        end

        // Freeze for 20 cycles inside a pipe.
        speed = 2'd0;
        for (int k = 0; k < 2 * SPAN && (m_shifts % SPAN) != GW + 1 && !timed_out; k++)
            wait_pulse(20, iv);
        held_gp = genPipes;
        held_pc = pipe_count;
        repeat (3) @(negedge Clock);
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            check("freeze_no_pulse", 32'(shift_en), 32'(0));
            check("freeze_hold_gp", 32'(genPipes), 32'(held_gp));
            check("freeze_hold_pc", 32'(pipe_count), 32'(held_pc));
        end
        freeze = 1'b0;
        wait_pulse(40, iv);
        check("freeze_resume_interval", 32'(iv), 32'(TB + 20));

        // Stop on the terminal-count cycle.
        repeat (TB - 1) @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        check("stop_tc_shift_en", 32'(shift_en), 32'(0));
        check("stop_tc_genPipes", 32'(genPipes), 32'(0));
        check("stop_tc_pipe_count", 32'(pipe_count), 32'(m_pipes));
        repeat (10) @(negedge Clock);
        check("stop_idle_shift_en", 32'(shift_en), 32'(0));

        // 300 pipes at speed 3 from the seeded LFSR.
        do_reset();
        speed = 2'd3;
        start = 1'b1;
        last_pulse = cyc + 1;
        for (int p = 0; p < 300 && !timed_out; p++) begin
            for (int c = 0; c < SPAN && !timed_out; c++) begin
                wait_pulse(10, iv);
                if (c == GW && !timed_out) begin
                    lz = lowest_zero(genPipes);
                    check("offset_range", 32'((lz >= 1) && (lz <= 15 - OH)), 32'(1));
                end
            end
        end
        check("pipe_count_saturated", 32'(pipe_count), 32'(255));

        // Randomized speed/freeze activity against the model.
        start = 1'b0;
        @(negedge Clock);
        timed_out = 1'b0;
        sb_start();
        speed = 2'($urandom_range(0, 3));
        start = 1'b1;
        @(negedge Clock);
        exp_period = TB >> speed;
        act = 0;
        prev_gp = genPipes;
        for (int i = 0; i < 3000; i++) begin
            f = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
            freeze = f;
            @(negedge Clock);
            if (!f) act++;
            check("rand_pulse", 32'(shift_en), 32'(!f && act == exp_period));
            if (shift_en) begin
                sb_pulse();
                act = 0;
                exp_period = TB >> speed;
            end else begin
                check("rand_hold", 32'(genPipes), 32'(prev_gp));
            end
            prev_gp = genPipes;
        end
        freeze = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
